// File: rtl/vga_fb_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter_if
// CPU load/store port into the framebuffer arbiter.
//   cpu_req   : request, held with stable fields until cpu_ack
//   cpu_we    : 1 = write, 0 = read
//   cpu_addr  : linear word address
//   cpu_wdata : write data
//   cpu_ack   : one-cycle completion pulse
//   cpu_rdata : read data, valid with cpu_ack, held until the next read ack
// Modports: master = CPU side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares the single synchronous-read framebuffer SRAM port between the VGA
// pixel fetch and a CPU load/store port. Display has priority; after MAX_WAIT
// consecutive denials the CPU is forced through for one slot.
//
// Ports:
//   clk, clrn        : clock, asynchronous active-low reset
//   disp_req         : display needs a pixel this cycle
//   h_addr, v_addr   : pixel column / row
//   vga_data         : pixel, registered two cycles after the request
//   disp_miss        : pulse; slot was taken by the CPU, vga_data repeats
//   cpu_bus          : CPU port (vga_fb_arbiter_if.slave)
//   mem_en, mem_we   : SRAM enable / write strobe (combinational from grant)
//   mem_addr         : SRAM word address
//   mem_wdata        : SRAM write data
//   mem_rdata        : SRAM read data, valid the cycle after a read enable
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              disp_req,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              disp_miss,
  vga_fb_arbiter_if.slave   cpu_bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(H_RES * V_RES);
  localparam logic [7:0]        WAIT_LIM = 8'(MAX_WAIT);

  // grant_q is the grant made in the previous cycle; together with cpu_ack it
  // also tells whether a CPU transaction is still outstanding.
  typedef enum logic [1:0] {G_IDLE, G_DISP, G_CPU} grant_t;

  grant_t            grant_d;
  grant_t            grant_q;
  logic [7:0]        wait_cnt;
  logic              d1_req;     // display request made last cycle
  logic              d1_oor;     // ... and it was off-screen
  logic              c1_we;      // CPU op granted last cycle was a write
  logic              c1_oor;     // ... and it was outside the framebuffer
  logic              disp_ok;
  logic              disp_in;
  logic              cpu_oor;
  logic              cpu_busy;
  logic              cpu_elig;
  logic [ADDR_W-1:0] disp_lin;

  // Linear pixel address; the default 640-wide line is 512 + 128.
  if (H_RES == 640) begin : g_shift
    assign disp_lin = (ADDR_W'(v_addr) << 9) + (ADDR_W'(v_addr) << 7)
                    + ADDR_W'(h_addr);
  end else begin : g_mul
    assign disp_lin = ADDR_W'(int'(v_addr) * H_RES + int'(h_addr));
  end

  assign disp_ok  = (int'(h_addr) < H_RES) && (int'(v_addr) < V_RES);
  assign disp_in  = disp_req && disp_ok;
  assign cpu_oor  = (cpu_bus.cpu_addr >= FB_WORDS);
  // Outstanding from grant up to and including the ack cycle, so a held
  // cpu_req is never taken as a second request.
  assign cpu_busy = (grant_q == G_CPU) || cpu_bus.cpu_ack;
  assign cpu_elig = cpu_bus.cpu_req && !cpu_busy;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/case leaves it unassigned and infers a latch.
  always_comb begin
    grant_d = G_IDLE;
    if (!clrn) begin
      grant_d = G_IDLE;
    end else if (cpu_elig && (!disp_in || wait_cnt >= WAIT_LIM)) begin
      grant_d = G_CPU;
    end else if (disp_in) begin
      grant_d = G_DISP;
    end
  end

  // SRAM strobes follow the grant in the same cycle. An out-of-range CPU
  // access still owns the slot but never touches the SRAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant_d)
      G_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_lin;
      end
      G_CPU: begin
        if (!cpu_oor) begin
          mem_en    = 1'b1;
          mem_we    = cpu_bus.cpu_we;
          mem_addr  = cpu_bus.cpu_addr;
          mem_wdata = cpu_bus.cpu_we ? cpu_bus.cpu_wdata : '0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      grant_q           <= G_IDLE;
      wait_cnt          <= '0;
      d1_req            <= 1'b0;
      d1_oor            <= 1'b0;
      c1_we             <= 1'b0;
      c1_oor            <= 1'b0;
      vga_data          <= '0;
      disp_miss         <= 1'b0;
      cpu_bus.cpu_ack   <= 1'b0;
      cpu_bus.cpu_rdata <= '0;
    end else begin
      grant_q <= grant_d;

      // Count consecutive denials of an eligible CPU.
      if (!cpu_elig || grant_d == G_CPU) begin
        wait_cnt <= '0;
      end else if (grant_d == G_DISP && wait_cnt < WAIT_LIM) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      d1_req <= disp_req;
      d1_oor <= !disp_ok;
      if (grant_d == G_CPU) begin
        c1_we  <= cpu_bus.cpu_we;
        c1_oor <= cpu_oor;
      end

      // Display response, fixed two-cycle latency.
      disp_miss <= 1'b0;
      if (d1_req) begin
        if (d1_oor) begin
          vga_data <= '0;
        end else if (grant_q == G_DISP) begin
          vga_data <= mem_rdata;
        end else begin
          disp_miss <= 1'b1;
        end
      end

      // Writes ack one cycle after grant, reads two (after the SRAM data).
      cpu_bus.cpu_ack <= (grant_d == G_CPU && cpu_bus.cpu_we)
                      || (grant_q == G_CPU && !c1_we);
      if (grant_q == G_CPU && !c1_we) begin
        cpu_bus.cpu_rdata <= c1_oor ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed stimulus with a scoreboard: the driver pushes expected display
// pixels and CPU completions into queues; a monitor on the falling edge pops
// and compares them as the DUT presents vga_data / cpu_ack. The SRAM model
// returns addr+0x100 for any word not yet written.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              clrn = 1'b1;
  logic              disp_req = 1'b0;
  logic [9:0]        h_addr = '0;
  logic [9:0]        v_addr = '0;
  logic [DATA_W-1:0] vga_data;
  logic              disp_miss;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();

  vga_fb_arbiter dut (
    .clk       (clk),
    .clrn      (clrn),
    .disp_req  (disp_req),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .vga_data  (vga_data),
    .disp_miss (disp_miss),
    .cpu_bus   (cpu_bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: synchronous read, words outside 0..2047 never written here.
  logic [DATA_W-1:0] sram    [0:2047];
  logic              written [0:2047] = '{default: 1'b0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_addr < 19'd2048) begin
          sram[mem_addr[10:0]]    <= mem_wdata;
          written[mem_addr[10:0]] <= 1'b1;
        end
      end else if (mem_addr < 19'd2048 && written[mem_addr[10:0]]) begin
        mem_rdata <= sram[mem_addr[10:0]];
      end else begin
        mem_rdata <= DATA_W'(mem_addr) + 24'h100;
      end
    end
  end

  // Scoreboard
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic              miss;
  } disp_exp_t;

  typedef struct {
    int                due;
    logic              is_rd;
    logic [DATA_W-1:0] rdata;
  } cpu_exp_t;

  disp_exp_t         disp_q [$];
  cpu_exp_t          cpu_q  [$];
  logic [DATA_W-1:0] model_pix = '0;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_disp(input logic [DATA_W-1:0] data, input logic miss);
    disp_q.push_back('{due: cyc + 2, data: data, miss: miss});
    if (!miss) model_pix = data;
  endtask

  task automatic push_cpu(input int due, input logic is_rd, input logic [DATA_W-1:0] rdata);
    cpu_q.push_back('{due: due, is_rd: is_rd, rdata: rdata});
  endtask

  // Monitor
  disp_exp_t de;
  cpu_exp_t  ce;
  always @(negedge clk) begin
    if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
      de = disp_q.pop_front();
      check("vga_data", 32'(vga_data), 32'(de.data));
      check("disp_miss", 32'(disp_miss), 32'(de.miss));
    end else begin
      check("disp_miss idle", 32'(disp_miss), 32'd0);
    end
    if (cpu_bus.cpu_ack) begin
      if (cpu_q.size() == 0) begin
        check("cpu_ack spurious", 32'(cpu_bus.cpu_ack), 32'd0);
      end else begin
        ce = cpu_q.pop_front();
        check("cpu_ack cycle", 32'(cyc), 32'(ce.due));
        if (ce.is_rd) check("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(ce.rdata));
      end
    end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
      ce = cpu_q.pop_front();
      check("cpu_ack missing", 32'(cpu_bus.cpu_ack), 32'd1);
    end
  end

  // Driver helpers: inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic en, input logic we,
                         input logic [ADDR_W-1:0] addr);
    #1;
    check({tag, " mem_en"}, 32'(mem_en), 32'(en));
    check({tag, " mem_we"}, 32'(mem_we), 32'(we));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    check({tag, " vga_data"}, 32'(vga_data), 32'd0);
    check({tag, " disp_miss"}, 32'(disp_miss), 32'd0);
    check({tag, " cpu_ack"}, 32'(cpu_bus.cpu_ack), 32'd0);
    check({tag, " cpu_rdata"}, 32'(cpu_bus.cpu_rdata), 32'd0);
    check({tag, " mem_en"}, 32'(mem_en), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
  endtask

  task automatic blank_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    tick();
    disp_req = 1'b0;
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = a;
    chk_mem("blank rd", 1'b1, 1'b0, a);
    push_cpu(cyc + 2, 1'b1, exp);
    tick();
    #1 check("blank rd busy mem_en", 32'(mem_en), 32'd0);
    tick();
    tick();
    cpu_bus.cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;
    #2 clrn = 1'b0;
    repeat (3) @(posedge clk);
    chk_all_zero("reset");
    clrn = 1'b1;
    tick();
    tick();
    #1 check("idle mem_en", 32'(mem_en), 32'd0);

    // Display stream, row 1, columns 0..3.
    for (int i = 0; i < 4; i++) begin
      tick();
      disp_req = 1'b1;
      v_addr   = 10'd1;
      h_addr   = 10'(i);
      chk_mem("disp stream", 1'b1, 1'b0, 19'(640 + i));
      push_disp(24'(640 + i + 256), 1'b0);
    end
    tick();
    disp_req = 1'b0;

    // Starvation guard: 8 display grants, then the CPU write in the 9th.
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      disp_req = 1'b1;
      v_addr   = 10'd2;
      h_addr   = 10'(i);
      cpu_bus.cpu_req   = (i <= 9);
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 19'd5;
      cpu_bus.cpu_wdata = 24'hABCDEF;
      if (i == 8) begin
        chk_mem("starve cpu", 1'b1, 1'b1, 19'd5);
        check("starve mem_wdata", 32'(mem_wdata), 32'h00ABCDEF);
        push_disp(model_pix, 1'b1);
        push_cpu(cyc + 1, 1'b0, '0);
      end else begin
        chk_mem("starve disp", 1'b1, 1'b0, 19'(1280 + i));
        push_disp(24'(1280 + i + 256), 1'b0);
      end
    end
    tick();
    disp_req = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    tick();

    // Blanking read of the word just written.
    blank_read(19'd5, 24'hABCDEF);

    // Out-of-range display and CPU read in the same cycle.
    tick();
    disp_req = 1'b1;
    h_addr   = 10'd700;
    v_addr   = 10'd0;
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 19'd307200;
    #1 check("oor mem_en", 32'(mem_en), 32'd0);
    push_disp('0, 1'b0);
    push_cpu(cyc + 2, 1'b1, '0);
    tick();
    disp_req = 1'b0;
    #1 check("oor busy mem_en", 32'(mem_en), 32'd0);
    tick();
    tick();
    cpu_bus.cpu_req = 1'b0;

    // Denial count: 3 denials, CPU withdraws for one cycle (count clears),
    // then a full 8 denials are needed again before the CPU write goes in.
    for (int i = 0; i < 15; i++) begin
      tick();
      disp_req = 1'b1;
      v_addr   = 10'd3;
      h_addr   = 10'(i);
      cpu_bus.cpu_req   = (i != 3) && (i != 14);
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 19'd6;
      cpu_bus.cpu_wdata = 24'h123456;
      if (i == 12) begin
        chk_mem("wait cpu", 1'b1, 1'b1, 19'd6);
        check("wait mem_wdata", 32'(mem_wdata), 32'h00123456);
        push_disp(model_pix, 1'b1);
        push_cpu(cyc + 1, 1'b0, '0);
      end else begin
        chk_mem("wait disp", 1'b1, 1'b0, 19'(1920 + i));
        push_disp(24'(1920 + i + 256), 1'b0);
      end
    end
    tick();
    disp_req = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    tick();
    blank_read(19'd6, 24'h123456);

    // Reset while a read is in flight: no ack, outputs clear at once.
    tick();
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 19'd5;
    chk_mem("pre-reset rd", 1'b1, 1'b0, 19'd5);
    tick();
    clrn = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    chk_all_zero("mid-read reset");
    repeat (3) tick();
    clrn = 1'b1;
    tick();
    tick();
    #1 check("post-reset mem_en", 32'(mem_en), 32'd0);
    repeat (4) tick();

    check("disp queue drained", 32'(disp_q.size()), 32'd0);
    check("cpu queue drained", 32'(cpu_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
